// File: rtl/chain_result_collector.sv
// Collector at the end of the die self-test chain: deserialises 14-bit result frames,
// checks stop bit and power sort order, and queues good frames in a show-ahead FIFO.
module chain_result_collector #(
  parameter int NUM_CHIPS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        t_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        data_in,
  input  logic        rd_en,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  output logic [4:0]  fifo_count,
  output logic [3:0]  frame_count,
  output logic        collect_done,
  output logic        frame_err,
  output logic        order_err,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      bit_cnt_r;
  logic [11:0]     shift_r;
  logic [3:0]      frame_count_r;
  logic            frame_err_r;
  logic            order_err_r;
  logic            overflow_r;
  logic            have_prev_r;
  logic [7:0]      prev_p_r;
  logic [11:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [4:0]      count_r;

  logic            arm_s;
  logic            good_s;
  logic            bad_s;
  logic            pop_s;
  logic            full_s;
  logic            wr_s;
  logic            drop_s;
  logic [3:0]      frame_inc_s;

  // Frame-completion and FIFO handshake decodes
  always_comb begin
    arm_s       = 1'b0;
    good_s      = 1'b0;
    bad_s       = 1'b0;
    pop_s       = 1'b0;
    full_s      = 1'b0;
    wr_s        = 1'b0;
    drop_s      = 1'b0;
    frame_inc_s = frame_count_r + 4'd1;
    if (state_r == ST_IDLE) begin
      arm_s = enable;
    end else begin
      arm_s = 1'b0;
    end
    if ((state_r == ST_STOP) && enable) begin
      good_s = ~data_in;
      bad_s  = data_in;
    end else begin
      good_s = 1'b0;
      bad_s  = 1'b0;
    end
    pop_s  = rd_en && (count_r != 5'd0);
    full_s = (count_r == 5'(FIFO_DEPTH));
    // A pop on the same edge frees the slot a full FIFO would otherwise refuse
    wr_s   = good_s && (!full_s || pop_s);
    drop_s = good_s && full_s && !pop_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_s = ST_HUNT;
        else        state_s = ST_IDLE;
      end
      ST_HUNT: begin
        if (!enable)     state_s = ST_IDLE;
        else if (data_in) state_s = ST_SHIFT;
        else             state_s = ST_HUNT;
      end
      ST_SHIFT: begin
        if (!enable)                state_s = ST_IDLE;
        else if (bit_cnt_r == 4'd11) state_s = ST_STOP;
        else                        state_s = ST_SHIFT;
      end
      ST_STOP: begin
        if (!enable)                                          state_s = ST_IDLE;
        else if (good_s && (frame_inc_s == 4'(NUM_CHIPS)))    state_s = ST_DONE;
        else                                                  state_s = ST_HUNT;
      end
      ST_DONE: begin
        if (!enable) state_s = ST_IDLE;
        else         state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge t_clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Deserialiser, run statistics and FIFO storage
  always_ff @(posedge t_clk) begin
    if (rst) begin
      bit_cnt_r     <= 4'd0;
      shift_r       <= 12'd0;
      frame_count_r <= 4'd0;
      frame_err_r   <= 1'b0;
      order_err_r   <= 1'b0;
      overflow_r    <= 1'b0;
      have_prev_r   <= 1'b0;
      prev_p_r      <= 8'd0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= 5'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 12'd0;
    end else begin
      if (state_r == ST_HUNT)  bit_cnt_r <= 4'd0;
      if (state_r == ST_SHIFT) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        shift_r   <= {shift_r[10:0], data_in};
      end
      if (arm_s) begin
        frame_count_r <= 4'd0;
        frame_err_r   <= 1'b0;
        order_err_r   <= 1'b0;
        overflow_r    <= 1'b0;
        have_prev_r   <= 1'b0;
      end
      if (good_s) begin
        frame_count_r <= frame_inc_s;
        have_prev_r   <= 1'b1;
        prev_p_r      <= shift_r[7:0];
        if (have_prev_r && (shift_r[7:0] > prev_p_r)) order_err_r <= 1'b1;
      end
      if (bad_s)  frame_err_r <= 1'b1;
      if (drop_s) overflow_r  <= 1'b1;
      if (wr_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data      = mem_r[rd_ptr_r];
  assign rd_valid     = (count_r != 5'd0);
  assign fifo_count   = count_r;
  assign frame_count  = frame_count_r;
  assign collect_done = (frame_count_r == 4'(NUM_CHIPS));
  assign frame_err    = frame_err_r;
  assign order_err    = order_err_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_chain_result_collector.sv
// Self-checking bench: directed scenarios plus randomized frames against a queue-based
// reference model of the collector's frame, order and FIFO rules.
module tb_chain_result_collector;
  localparam int NUM_CHIPS = 8;
  localparam int DEPTH     = 8;

  logic        t_clk = 1'b0;
  logic        rst, enable, data_in, rd_en;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic [3:0]  frame_count;
  logic        collect_done, frame_err, order_err, overflow;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [11:0] mq[$];
  int          m_fc;
  bit          m_ferr, m_oerr, m_ovf, m_have_prev;
  logic [7:0]  m_prev;
  int          pop_pct;

  chain_result_collector #(.NUM_CHIPS(NUM_CHIPS), .FIFO_DEPTH(DEPTH)) dut (
    .t_clk(t_clk), .rst(rst), .enable(enable), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .frame_count(frame_count), .collect_done(collect_done), .frame_err(frame_err),
    .order_err(order_err), .overflow(overflow)
  );

  always #5 t_clk = ~t_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check_eq("rd_data", 32'(rd_data), 32'(mq[0]));
    check_eq("frame_count", 32'(frame_count), 32'(m_fc));
    check_eq("collect_done", 32'(collect_done), 32'(m_fc == NUM_CHIPS));
    check_eq("frame_err", 32'(frame_err), 32'(m_ferr));
    check_eq("order_err", 32'(order_err), 32'(m_oerr));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic clear_stats();
    m_fc = 0; m_ferr = 1'b0; m_oerr = 1'b0; m_ovf = 1'b0; m_have_prev = 1'b0;
  endtask

  // One clock: drive inputs, advance past the edge, update the model, compare.
  task automatic step(input logic din, input logic rd, input bit stop_edge,
                      input logic [11:0] frame, input bit arm_edge);
    bit pop, full, good;
    data_in = din;
    rd_en   = rd;
    pop  = rd && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    good = stop_edge && enable && !din;
    @(posedge t_clk);
    #1;
    if (arm_edge) clear_stats();
    if (stop_edge && enable && din) m_ferr = 1'b1;
    if (good) begin
      m_fc++;
      if (m_have_prev && (frame[7:0] > m_prev)) m_oerr = 1'b1;
      m_prev = frame[7:0];
      m_have_prev = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (good) begin
      if (!full || pop) mq.push_back(frame);
      else              m_ovf = 1'b1;
    end
    check_all();
  endtask

  function automatic logic rnd_rd();
    return ($urandom_range(0, 99) < pop_pct);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd_rd(), 1'b0, 12'd0, 1'b0);
  endtask

  task automatic send_frame(input logic [11:0] f, input logic stop_bit,
                            input bit use_rnd, input logic rd_stop);
    step(1'b1, rnd_rd(), 1'b0, f, 1'b0);
    for (int i = 11; i >= 0; i--) step(f[i], rnd_rd(), 1'b0, f, 1'b0);
    step(stop_bit, use_rnd ? rnd_rd() : rd_stop, 1'b1, f, 1'b0);
  endtask

  task automatic arm();
    enable = 1'b1;
    step(1'b0, rnd_rd(), 1'b0, 12'd0, 1'b1);
  endtask

  task automatic disarm();
    enable = 1'b0;
    step(1'b0, rnd_rd(), 1'b0, 12'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) step(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; data_in = 1'b0; rd_en = 1'b0;
    @(posedge t_clk);
    #1;
    mq.delete();
    clear_stats();
    check_all();
    check_eq("rd_data_rst", 32'(rd_data), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] f;
    int          cur_p, p, nfr;
    rst = 1'b1; enable = 1'b0; data_in = 1'b0; rd_en = 1'b0; pop_pct = 0;
    m_prev = 8'd0;
    do_reset();

    // Eight clean descending frames, then ordered pops
    arm();
    for (int i = 0; i < 8; i++) begin
      f = {4'(i), 8'(8'hF0 - 8'(16 * i))};
      send_frame(f, 1'b0, 1'b0, 1'b0);
    end
    check_eq("done_after_8", 32'(collect_done), 32'd1);
    check_eq("count_after_8", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      f = {4'(i), 8'(8'hF0 - 8'(16 * i))};
      check_eq("pop_order", 32'(rd_data), 32'(f));
      step(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
    end

    // Frame 3 with a bad stop bit; ninth frame completes the run
    disarm();
    arm();
    for (int i = 0; i < 9; i++) begin
      f = {4'(i), 8'(8'hA0 - 8'(8 * i))};
      send_frame(f, (i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
    check_eq("ferr_set", 32'(frame_err), 32'd1);
    drain();

    // Equal powers are legal, a rise is not
    disarm();
    arm();
    send_frame(12'h050, 1'b0, 1'b0, 1'b0);
    send_frame(12'h150, 1'b0, 1'b0, 1'b0);
    check_eq("oerr_equal", 32'(order_err), 32'd0);
    send_frame(12'h260, 1'b0, 1'b0, 1'b0);
    check_eq("oerr_rise", 32'(order_err), 32'd1);

    // Fill to full, simultaneous push/pop, then overflow
    disarm();
    arm();
    for (int i = 0; i < 5; i++) send_frame({4'(i), 8'(8'h40 - 8'(i))}, 1'b0, 1'b0, 1'b0);
    check_eq("full_count", 32'(fifo_count), 32'd8);
    send_frame(12'h530, 1'b0, 1'b0, 1'b1);
    check_eq("pushpop_ovf", 32'(overflow), 32'd0);
    send_frame(12'h620, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(overflow), 32'd1);

    // Abort mid-frame at data bit 6, then re-arm clears the flags
    step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 12'd0, 1'b0);
    enable = 1'b0;
    step(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    check_eq("abort_fc", 32'(frame_count), 32'd7);
    arm();
    check_eq("rearm_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset in the middle of a frame with the FIFO occupied
    send_frame(12'h7AA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    do_reset();
    enable = 1'b0;
    step(1'b0, 1'b0, 1'b0, 12'd0, 1'b0);

    // Randomized runs
    for (int run = 0; run < 8; run++) begin
      pop_pct = $urandom_range(0, 60);
      cur_p = 255;
      arm();
      nfr = $urandom_range(3, 12);
      for (int k = 0; k < nfr && m_fc < NUM_CHIPS; k++) begin
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) p = $urandom_range(0, 255);
        else begin
          p = cur_p - $urandom_range(0, 32);
          if (p < 0) p = 0;
        end
        cur_p = p;
        f = {4'($urandom_range(0, 15)), 8'(p)};
        send_frame(f, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      end
      idle($urandom_range(0, 4));
      disarm();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
